// File: rtl/muu_mem_arbiter.sv
// muu_mem_arbiter: shares one memory-controller port (wrcmd / wr data / rdcmd) between two requesters
// Optional feature: define MUU_ARB_STATS_EN to add per-port 32-bit command/beat counters.
// Ports:
//   clk, rst               clock, synchronous active-low reset
//   s_wrcmd_*              per-port write commands {beats[39:32], addr[31:0]}, port i at [i*CMD_WIDTH +: CMD_WIDTH]
//   s_wr_*                 per-port write data beats
//   s_rdcmd_*              per-port read commands
//   m_wrcmd_*              registered write command slot toward the DRAM command FIFO
//   m_wr_*                 combinational write data path of the current burst owner
//   m_rdcmd_*              registered read command slot
//   wr_owner               currently / last granted write port
//   stat_*                 (MUU_ARB_STATS_EN only) per-port accepted bursts, beats and read commands
module muu_mem_arbiter #(
   parameter int MEMORY_WIDTH = 512,
   parameter int CMD_WIDTH    = 40
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [2*CMD_WIDTH-1:0]    s_wrcmd_data,
   input  logic [1:0]                s_wrcmd_valid,
   output logic [1:0]                s_wrcmd_ready,
   input  logic [2*MEMORY_WIDTH-1:0] s_wr_data,
   input  logic [1:0]                s_wr_valid,
   output logic [1:0]                s_wr_ready,
   input  logic [2*CMD_WIDTH-1:0]    s_rdcmd_data,
   input  logic [1:0]                s_rdcmd_valid,
   output logic [1:0]                s_rdcmd_ready,
   output logic [CMD_WIDTH-1:0]      m_wrcmd_data,
   output logic                      m_wrcmd_valid,
   input  logic                      m_wrcmd_ready,
   output logic [MEMORY_WIDTH-1:0]   m_wr_data,
   output logic                      m_wr_valid,
   input  logic                      m_wr_ready,
   output logic [CMD_WIDTH-1:0]      m_rdcmd_data,
   output logic                      m_rdcmd_valid,
   input  logic                      m_rdcmd_ready,
   output logic                      wr_owner
`ifdef MUU_ARB_STATS_EN
   ,
   output logic [63:0]               stat_wr_bursts,
   output logic [63:0]               stat_wr_beats,
   output logic [63:0]               stat_rd_cmds
`endif
);
   typedef enum logic {WR_IDLE, WR_DATA} wr_state_e;

   wr_state_e              wr_state_q, wr_state_d;
   logic [7:0]             cnt_q, cnt_d;
   logic                   wr_owner_q, wr_owner_d;
   logic                   wr_prio_q, wr_prio_d;
   logic [CMD_WIDTH-1:0]   m_wrcmd_data_q, m_wrcmd_data_d;
   logic                   m_wrcmd_valid_q, m_wrcmd_valid_d;
   logic                   rd_prio_q, rd_prio_d;
   logic [CMD_WIDTH-1:0]   m_rdcmd_data_q, m_rdcmd_data_d;
   logic                   m_rdcmd_valid_q, m_rdcmd_valid_d;
   logic                   wr_win, wr_acc, rd_win, rd_acc;
   logic [CMD_WIDTH-1:0]   wr_cmd, rd_cmd;

   assign m_wrcmd_data  = m_wrcmd_data_q;
   assign m_wrcmd_valid = m_wrcmd_valid_q;
   assign m_rdcmd_data  = m_rdcmd_data_q;
   assign m_rdcmd_valid = m_rdcmd_valid_q;
   assign wr_owner      = wr_owner_q;
   assign m_wr_data     = wr_owner_q ? s_wr_data[MEMORY_WIDTH +: MEMORY_WIDTH] : s_wr_data[0 +: MEMORY_WIDTH];

   // Round robin: with both ports requesting, the priority pointer (the port that did not win last) wins.
   assign wr_win = (&s_wrcmd_valid) ? wr_prio_q : s_wrcmd_valid[1];
   assign rd_win = (&s_rdcmd_valid) ? rd_prio_q : s_rdcmd_valid[1];
   assign wr_cmd = wr_win ? s_wrcmd_data[CMD_WIDTH +: CMD_WIDTH] : s_wrcmd_data[0 +: CMD_WIDTH];
   assign rd_cmd = rd_win ? s_rdcmd_data[CMD_WIDTH +: CMD_WIDTH] : s_rdcmd_data[0 +: CMD_WIDTH];
   // Readies are gated by rst so nothing handshakes while reset is held.
   assign wr_acc = rst && wr_state_q == WR_IDLE && |s_wrcmd_valid && (!m_wrcmd_valid_q || m_wrcmd_ready);
   assign rd_acc = rst && |s_rdcmd_valid && (!m_rdcmd_valid_q || m_rdcmd_ready);

   always_comb begin
      wr_state_d      = wr_state_q;
      cnt_d           = cnt_q;
      wr_owner_d      = wr_owner_q;
      wr_prio_d       = wr_prio_q;
      m_wrcmd_data_d  = m_wrcmd_data_q;
      m_wrcmd_valid_d = m_wrcmd_valid_q && !m_wrcmd_ready;
      s_wrcmd_ready   = '0;
      s_wr_ready      = '0;
      m_wr_valid      = 1'b0;
      if (wr_acc) begin
         s_wrcmd_ready[wr_win] = 1'b1;
         m_wrcmd_data_d        = wr_cmd;
         m_wrcmd_valid_d       = 1'b1;
         cnt_d                 = wr_cmd[CMD_WIDTH-1 -: 8];
         wr_owner_d            = wr_win;
         wr_prio_d             = !wr_win;
         wr_state_d            = wr_cmd[CMD_WIDTH-1 -: 8] != 8'd0 ? WR_DATA : WR_IDLE;
      end
      if (rst && wr_state_q == WR_DATA) begin
         m_wr_valid              = s_wr_valid[wr_owner_q];
         s_wr_ready[wr_owner_q]  = m_wr_ready;
         if (m_wr_valid && m_wr_ready) begin
            cnt_d      = cnt_q - 8'd1;
            wr_state_d = cnt_q == 8'd1 ? WR_IDLE : WR_DATA;
         end
      end
   end

   always_comb begin
      rd_prio_d       = rd_prio_q;
      m_rdcmd_data_d  = m_rdcmd_data_q;
      m_rdcmd_valid_d = m_rdcmd_valid_q && !m_rdcmd_ready;
      s_rdcmd_ready   = '0;
      if (rd_acc) begin
         s_rdcmd_ready[rd_win] = 1'b1;
         m_rdcmd_data_d        = rd_cmd;
         m_rdcmd_valid_d       = 1'b1;
         rd_prio_d             = !rd_win;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_state_q      <= WR_IDLE;
         cnt_q           <= '0;
         wr_owner_q      <= 1'b0;
         wr_prio_q       <= 1'b0;
         m_wrcmd_data_q  <= '0;
         m_wrcmd_valid_q <= 1'b0;
         rd_prio_q       <= 1'b0;
         m_rdcmd_data_q  <= '0;
         m_rdcmd_valid_q <= 1'b0;
      end else begin
         wr_state_q      <= wr_state_d;
         cnt_q           <= cnt_d;
         wr_owner_q      <= wr_owner_d;
         wr_prio_q       <= wr_prio_d;
         m_wrcmd_data_q  <= m_wrcmd_data_d;
         m_wrcmd_valid_q <= m_wrcmd_valid_d;
         rd_prio_q       <= rd_prio_d;
         m_rdcmd_data_q  <= m_rdcmd_data_d;
         m_rdcmd_valid_q <= m_rdcmd_valid_d;
      end
   end

`ifdef MUU_ARB_STATS_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_wr_bursts <= '0;
         stat_wr_beats  <= '0;
         stat_rd_cmds   <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (s_wrcmd_valid[i] && s_wrcmd_ready[i]) stat_wr_bursts[i*32 +: 32] <= stat_wr_bursts[i*32 +: 32] + 32'd1;
            if (s_wr_valid[i] && s_wr_ready[i])       stat_wr_beats[i*32 +: 32]  <= stat_wr_beats[i*32 +: 32] + 32'd1;
            if (s_rdcmd_valid[i] && s_rdcmd_ready[i]) stat_rd_cmds[i*32 +: 32]   <= stat_rd_cmds[i*32 +: 32] + 32'd1;
         end
      end
   end
`endif
endmodule

// File: tb/tb_muu_mem_arbiter.sv
// tb_muu_mem_arbiter: directed self-checking bench for muu_mem_arbiter
module tb_muu_mem_arbiter;
   logic          clk = 1'b0;
   logic          rst;
   logic [79:0]   s_wrcmd_data, s_rdcmd_data;
   logic [1:0]    s_wrcmd_valid, s_wrcmd_ready, s_wr_valid, s_wr_ready, s_rdcmd_valid, s_rdcmd_ready;
   logic [1023:0] s_wr_data;
   logic [39:0]   m_wrcmd_data, m_rdcmd_data;
   logic          m_wrcmd_valid, m_wrcmd_ready, m_wr_valid, m_wr_ready, m_rdcmd_valid, m_rdcmd_ready, wr_owner;
   logic [511:0]  m_wr_data;
   int            n_cmp = 0;
   int            n_err = 0;

   muu_mem_arbiter dut (
      .clk(clk), .rst(rst),
      .s_wrcmd_data(s_wrcmd_data), .s_wrcmd_valid(s_wrcmd_valid), .s_wrcmd_ready(s_wrcmd_ready),
      .s_wr_data(s_wr_data), .s_wr_valid(s_wr_valid), .s_wr_ready(s_wr_ready),
      .s_rdcmd_data(s_rdcmd_data), .s_rdcmd_valid(s_rdcmd_valid), .s_rdcmd_ready(s_rdcmd_ready),
      .m_wrcmd_data(m_wrcmd_data), .m_wrcmd_valid(m_wrcmd_valid), .m_wrcmd_ready(m_wrcmd_ready),
      .m_wr_data(m_wr_data), .m_wr_valid(m_wr_valid), .m_wr_ready(m_wr_ready),
      .m_rdcmd_data(m_rdcmd_data), .m_rdcmd_valid(m_rdcmd_valid), .m_rdcmd_ready(m_rdcmd_ready),
      .wr_owner(wr_owner)
   );

   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b0;
      s_wrcmd_data = '0; s_rdcmd_data = '0; s_wr_data = '0;
      s_wrcmd_valid = 2'b11; s_wr_valid = 2'b00; s_rdcmd_valid = 2'b11;
      m_wrcmd_ready = 1'b1; m_wr_ready = 1'b1; m_rdcmd_ready = 1'b1;
      step; step;
      chk("rst_wrcmd_ready", 512'(s_wrcmd_ready), 512'd0);
      chk("rst_rdcmd_ready", 512'(s_rdcmd_ready), 512'd0);
      chk("rst_wr_ready", 512'(s_wr_ready), 512'd0);
      chk("rst_m_wrcmd_valid", 512'(m_wrcmd_valid), 512'd0);
      chk("rst_m_rdcmd_valid", 512'(m_rdcmd_valid), 512'd0);
      chk("rst_m_wr_valid", 512'(m_wr_valid), 512'd0);
      chk("rst_wr_owner", 512'(wr_owner), 512'd0);
      s_wrcmd_valid = 2'b00; s_rdcmd_valid = 2'b00;

      // single port 0 burst of 3 beats
      rst = 1'b1;
      s_wrcmd_data[39:0] = 40'h03_00000100; s_wrcmd_valid = 2'b01;
      s_wr_data[511:0] = 512'hA1; s_wr_valid = 2'b01;
      #1;
      chk("t1_grant_ready", 512'(s_wrcmd_ready), 512'h1);
      chk("t1_no_beat_in_idle", 512'(m_wr_valid), 512'd0);
      step;
      s_wrcmd_valid = 2'b00;
      #1;
      chk("t1_m_wrcmd_data", 512'(m_wrcmd_data), 512'h03_00000100);
      chk("t1_m_wrcmd_valid", 512'(m_wrcmd_valid), 512'd1);
      chk("t1_owner", 512'(wr_owner), 512'd0);
      chk("t1_beat1_valid", 512'(m_wr_valid), 512'd1);
      chk("t1_beat1_data", m_wr_data, 512'hA1);
      chk("t1_beat1_ready", 512'(s_wr_ready), 512'h1);
      step;
      s_wr_data[511:0] = 512'hA2;
      #1;
      chk("t1_wrcmd_drained", 512'(m_wrcmd_valid), 512'd0);
      chk("t1_beat2_data", m_wr_data, 512'hA2);
      step;
      s_wr_data[511:0] = 512'hA3;
      #1;
      chk("t1_beat3_valid", 512'(m_wr_valid), 512'd1);
      chk("t1_beat3_data", m_wr_data, 512'hA3);
      step;
      s_wr_data[511:0] = 512'hA4;
      #1;
      chk("t1_idle_no_beat", 512'(m_wr_valid), 512'd0);
      chk("t1_idle_wr_ready", 512'(s_wr_ready), 512'd0);
      s_wr_valid = 2'b00;

      // both ports request len 2 straight out of reset
      rst = 1'b0;
      step;
      rst = 1'b1;
      s_wrcmd_data = {40'h02_00000300, 40'h02_00000200}; s_wrcmd_valid = 2'b11;
      s_wr_data = {512'hB1, 512'hC1}; s_wr_valid = 2'b11;
      #1;
      chk("t2_grant_p0", 512'(s_wrcmd_ready), 512'h1);
      step;
      s_wrcmd_valid = 2'b10;
      #1;
      chk("t2_hold_p1_cmd", 512'(s_wrcmd_ready), 512'd0);
      chk("t2_p1_beats_blocked", 512'(s_wr_ready), 512'h1);
      chk("t2_p0_cmd", 512'(m_wrcmd_data), 512'h02_00000200);
      chk("t2_p0_beat1", m_wr_data, 512'hC1);
      step;
      s_wr_data[511:0] = 512'hC2;
      #1;
      chk("t2_p1_still_blocked", 512'(s_wr_ready), 512'h1);
      chk("t2_p0_beat2", m_wr_data, 512'hC2);
      step;
      s_wr_valid = 2'b10;
      #1;
      chk("t2_grant_p1", 512'(s_wrcmd_ready), 512'h2);
      chk("t2_no_early_p1_beat", 512'(m_wr_valid), 512'd0);
      chk("t2_owner_still_p0", 512'(wr_owner), 512'd0);
      step;
      s_wrcmd_valid = 2'b00;
      #1;
      chk("t2_owner_p1", 512'(wr_owner), 512'd1);
      chk("t2_p1_cmd", 512'(m_wrcmd_data), 512'h02_00000300);
      chk("t2_p1_ready", 512'(s_wr_ready), 512'h2);
      chk("t2_p1_beat1", m_wr_data, 512'hB1);
      step;
      s_wr_data[1023:512] = 512'hB2;
      #1;
      chk("t2_p1_beat2", m_wr_data, 512'hB2);
      step;
      s_wr_valid = 2'b00;

      // len 0 on port 0, then len 1 on port 1
      s_wrcmd_data = {40'h01_00000500, 40'h00_00000400}; s_wrcmd_valid = 2'b11;
      s_wr_data[1023:512] = 512'hD1; s_wr_valid = 2'b10;
      #1;
      chk("t4_grant_p0", 512'(s_wrcmd_ready), 512'h1);
      step;
      s_wrcmd_valid = 2'b10;
      #1;
      chk("t4_len0_cmd", 512'(m_wrcmd_data), 512'h00_00000400);
      chk("t4_len0_no_data", 512'(m_wr_valid), 512'd0);
      chk("t4_grant_p1_next", 512'(s_wrcmd_ready), 512'h2);
      step;
      s_wrcmd_valid = 2'b00;
      #1;
      chk("t4_p1_cmd", 512'(m_wrcmd_data), 512'h01_00000500);
      chk("t4_p1_beat", m_wr_data, 512'hD1);
      chk("t4_p1_valid", 512'(m_wr_valid), 512'd1);
      step;
      s_wr_valid = 2'b00;
      #1;
      chk("t4_back_idle", 512'(s_wr_ready), 512'd0);

      // both read ports valid, m_rdcmd_ready toggling 1/0
      s_rdcmd_data = {40'h00_0000B000, 40'h00_0000A000}; s_rdcmd_valid = 2'b11;
      m_rdcmd_ready = 1'b1;
      #1;
      chk("rd_c0_ready", 512'(s_rdcmd_ready), 512'h1);
      step;
      s_rdcmd_data[39:0] = 40'h00_0000A001; m_rdcmd_ready = 1'b0;
      #1;
      chk("rd_c1_ready", 512'(s_rdcmd_ready), 512'd0);
      chk("rd_c1_valid", 512'(m_rdcmd_valid), 512'd1);
      chk("rd_c1_data", 512'(m_rdcmd_data), 512'hA000);
      step;
      m_rdcmd_ready = 1'b1;
      #1;
      chk("rd_c2_ready", 512'(s_rdcmd_ready), 512'h2);
      chk("rd_c2_data", 512'(m_rdcmd_data), 512'hA000);
      step;
      s_rdcmd_data[79:40] = 40'h00_0000B001; m_rdcmd_ready = 1'b0;
      #1;
      chk("rd_c3_ready", 512'(s_rdcmd_ready), 512'd0);
      chk("rd_c3_data", 512'(m_rdcmd_data), 512'hB000);
      step;
      m_rdcmd_ready = 1'b1;
      #1;
      chk("rd_c4_ready", 512'(s_rdcmd_ready), 512'h1);
      step;
      m_rdcmd_ready = 1'b0;
      #1;
      chk("rd_c5_data", 512'(m_rdcmd_data), 512'hA001);
      chk("rd_c5_valid", 512'(m_rdcmd_valid), 512'd1);
      step;
      s_rdcmd_valid = 2'b00; m_rdcmd_ready = 1'b1;
      step;
      chk("rd_drained", 512'(m_rdcmd_valid), 512'd0);

      // reset in the middle of a 4-beat port 1 burst
      s_wrcmd_data[79:40] = 40'h04_00000600; s_wrcmd_valid = 2'b10;
      s_wr_data[1023:512] = 512'hE1; s_wr_valid = 2'b10;
      step;
      s_wrcmd_valid = 2'b00; m_wrcmd_ready = 1'b0;
      #1;
      chk("t6_owner_p1", 512'(wr_owner), 512'd1);
      step;
      s_wr_data[1023:512] = 512'hE2; rst = 1'b0;
      #1;
      chk("t6_rst_wr_ready", 512'(s_wr_ready), 512'd0);
      chk("t6_rst_m_wr_valid", 512'(m_wr_valid), 512'd0);
      step;
      chk("t6_m_wrcmd_valid", 512'(m_wrcmd_valid), 512'd0);
      chk("t6_owner_cleared", 512'(wr_owner), 512'd0);
      rst = 1'b1; m_wrcmd_ready = 1'b1;
      s_wrcmd_data[39:0] = 40'h01_00000700; s_wrcmd_valid = 2'b01;
      s_wr_data[511:0] = 512'hF1; s_wr_valid = 2'b11;
      #1;
      chk("t6_no_drain", 512'(m_wr_valid), 512'd0);
      chk("t6_clean_grant", 512'(s_wrcmd_ready), 512'h1);
      step;
      s_wrcmd_valid = 2'b00;
      #1;
      chk("t6_new_cmd", 512'(m_wrcmd_data), 512'h01_00000700);
      chk("t6_new_beat", m_wr_data, 512'hF1);
      chk("t6_new_ready", 512'(s_wr_ready), 512'h1);
      step;
      s_wr_valid = 2'b00;
      step;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
